// File: rtl/avg_pkg.sv
// Shared widths, raster geometry and FSM state type for the averaging front end.
// The DONE state exists only when AVG_FRAME_LIMIT_EN is defined.
`ifndef PIXEL_COLUMN
`define PIXEL_COLUMN 4
`endif
`ifndef PIXEL_ROW
`define PIXEL_ROW 3
`endif

package avg_pkg;

  localparam int AVG_TERM_W = 35;
  localparam int AVG_SUM_W  = 16;
  localparam int AVG_OLD_W  = 9;

  localparam int PX_COLS = `PIXEL_COLUMN;
  localparam int PX_ROWS = `PIXEL_ROW;
  localparam int PX_W    = (PX_COLS > 1) ? $clog2(PX_COLS) : 1;
  localparam int PY_W    = (PX_ROWS > 1) ? $clog2(PX_ROWS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RD,
    ST_WR,
    ST_STALL
`ifdef AVG_FRAME_LIMIT_EN
    , ST_DONE
`endif
  } avg_feed_state_e;

endpackage

// File: rtl/avg_square_scale.sv
// Squares one signed sample exactly and divides the energy term by the window
// length with a right shift.
module avg_square_scale
  import avg_pkg::*;
#(
  parameter int IN_W  = AVG_SUM_W,
  parameter int SHIFT = 4
) (
  input  logic [IN_W-1:0]       i_val,
  output logic [AVG_TERM_W-1:0] o_term
);

  logic [IN_W-1:0]       mag;
  logic [2*IN_W-1:0]     mag_ext;
  logic [2*IN_W-1:0]     sq;
  logic [AVG_TERM_W-1:0] sq_ext;

  // Unsigned magnitude: the most negative input maps to 2^(IN_W-1) without overflow.
  always_comb begin
    mag     = i_val[IN_W-1] ? ((~i_val) + IN_W'(1)) : i_val;
    mag_ext = {{IN_W{1'b0}}, mag};
    sq      = mag_ext * mag_ext;
    sq_ext  = AVG_TERM_W'(sq);
    o_term  = sq_ext >> SHIFT;
  end

endmodule

// File: rtl/avg_feed_ctrl.sv
// Pixel-scan controller and energy-term front end for the running-average SRAM stage.
// Define AVG_FRAME_LIMIT_EN to stop in DONE after N_FRAMES frames.
module avg_feed_ctrl
  import avg_pkg::*;
#(
  parameter int LOG2_L = 4
`ifdef AVG_FRAME_LIMIT_EN
  , parameter int N_FRAMES = 64
`endif
) (
  input  logic                  i_50M_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [AVG_SUM_W-1:0]  i_new_sum,
  input  logic [AVG_OLD_W-1:0]  i_old_sum,
  output logic                  o_ready,
  output logic                  o_init_valid,
  output logic                  o_calc_valid,
  output logic                  o_stop,
  output logic [PX_W-1:0]       o_px,
  output logic [PY_W-1:0]       o_py,
  output logic [AVG_TERM_W-1:0] o_new_data,
  output logic [AVG_TERM_W-1:0] o_old_data,
  output logic [15:0]           o_frame,
  output logic                  o_busy
);

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(PX_COLS - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(PX_ROWS - 1);

  avg_feed_state_e       state_q, state_d;
  logic [PX_W-1:0]       px_q, px_d;
  logic [PY_W-1:0]       py_q, py_d;
  logic [15:0]           frame_q, frame_d;
  logic [AVG_TERM_W-1:0] new_data_q, new_data_d;
  logic [AVG_TERM_W-1:0] old_data_q, old_data_d;
  logic [AVG_TERM_W-1:0] new_term, old_term;

  logic last_px;
  logic frame_last;
  logic start_go;
  logic accept;

  avg_square_scale #(.IN_W(AVG_SUM_W), .SHIFT(LOG2_L)) u_sq_new (
    .i_val  (i_new_sum),
    .o_term (new_term)
  );

  avg_square_scale #(.IN_W(AVG_OLD_W), .SHIFT(LOG2_L)) u_sq_old (
    .i_val  (i_old_sum),
    .o_term (old_term)
  );

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    last_px = (px_q == PX_LAST) && (py_q == PY_LAST);
`ifdef AVG_FRAME_LIMIT_EN
    frame_last = (frame_q == 16'(N_FRAMES - 1));
    start_go   = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`else
    frame_last = 1'b0;
    start_go   = i_start && (state_q == ST_IDLE);
`endif
    accept = (state_q == ST_RD) && i_valid;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_START;
      ST_START: state_d = ST_RD;
      ST_RD:    state_d = i_valid ? ST_WR : ST_STALL;
      ST_STALL: if (i_valid) state_d = ST_RD;
      ST_WR:    state_d = (last_px && frame_last) ?
`ifdef AVG_FRAME_LIMIT_EN
                          ST_DONE
`else
                          ST_IDLE
`endif
                          : ST_RD;
`ifdef AVG_FRAME_LIMIT_EN
      ST_DONE:  if (i_start) state_d = ST_START;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster walks rows inside columns; the frame count saturates rather than wraps.
  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    frame_d = frame_q;
    if (state_q == ST_WR) begin
      if (py_q == PY_LAST) begin
        py_d = '0;
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (frame_q != '1) frame_d = frame_q + 16'd1;
        end else begin
          px_d = px_q + PX_W'(1);
        end
      end else begin
        py_d = py_q + PY_W'(1);
      end
    end
    if (start_go) begin
      px_d    = '0;
      py_d    = '0;
      frame_d = '0;
    end
    new_data_d = accept ? new_term : new_data_q;
    old_data_d = accept ? old_term : old_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      frame_q    <= '0;
      new_data_q <= '0;
      old_data_q <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      frame_q    <= frame_d;
      new_data_q <= new_data_d;
      old_data_q <= old_data_d;
    end
  end

  // o_stop is combinational so it drops in the very cycle i_valid returns.
  always_comb begin
    o_ready      = 1'b0;
    o_init_valid = 1'b0;
    o_calc_valid = 1'b0;
    o_stop       = 1'b0;
    o_busy       = 1'b1;
    case (state_q)
      ST_IDLE:  o_busy = 1'b0;
      ST_START: o_init_valid = 1'b1;
      ST_RD: begin
        o_ready = 1'b1;
        o_stop  = !i_valid;
      end
      ST_STALL: o_stop = !i_valid;
      ST_WR: begin
        o_calc_valid = last_px && (frame_q == 16'd0);
        o_stop       = last_px && frame_last;
      end
`ifdef AVG_FRAME_LIMIT_EN
      ST_DONE: begin
        o_busy = 1'b0;
        o_stop = 1'b1;
      end
`endif
      default: o_busy = 1'b0;
    endcase
  end

  assign o_px       = px_q;
  assign o_py       = py_q;
  assign o_frame    = frame_q;
  assign o_new_data = new_data_q;
  assign o_old_data = old_data_q;

endmodule
